// File: rtl/tx_shift_datapath.sv
// -----------------------------------------------------------------------------
// tx_shift_datapath
//
// UART transmit datapath that sits downstream of tx_controller. A load strobe
// captures a parallel word and frames it as
//   start bit (0), data bits LSB first, optional parity bit, stop bit(s) (1).
// Each qualified shift (shift enable level AND baud tick while a frame is in
// flight) moves the next frame bit onto the registered serial output. Once the
// last frame bit has been shifted out, a one-cycle completion pulse is returned
// to tx_controller.
//
// Parameters
//   DATA_W      data bits per frame (5..9)
//   PARITY_EN   1 = append a parity bit after the data bits
//   PARITY_ODD  1 = odd parity, 0 = even parity (ignored when PARITY_EN = 0)
//   STOP_BITS   number of stop bits (1 or 2)
//
// Ports
//   clk            in   1       system clock, rising edge
//   reset          in   1       asynchronous reset, active low
//   ctrl_sr_load   in   1       load a new frame from data_in
//   ctrl_sr_shift  in   1       shift enable level from tx_controller
//   ctrl_baud      in   1       one-cycle baud tick
//   data_in        in   DATA_W  word to transmit, sampled on load
//   tx             out  1       serial line, idle high
//   ctrl_counter   out  1       one-cycle pulse: frame completely sent
//   busy           out  1       high from load until frame complete
//   err_overrun    out  1       sticky: a load arrived while busy
// -----------------------------------------------------------------------------
module tx_shift_datapath #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_sr_load,
  input  logic              ctrl_sr_shift,
  input  logic              ctrl_baud,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx,
  output logic              ctrl_counter,
  output logic              busy,
  output logic              err_overrun
);

  localparam int FRAME_LEN = 1 + DATA_W + PARITY_EN + STOP_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   ctrl_counter_q, ctrl_counter_d;
  logic                   err_overrun_q, err_overrun_d;

  logic                   parity_bit;
  logic [FRAME_LEN-1:0]   load_frame;
  logic                   shift_qual;

  // Parity is taken over the sampled data word; XOR with the odd flag turns
  // even parity into odd parity.
  assign parity_bit = (^data_in) ^ (PARITY_ODD != 0);

  // Frame image as it will leave the shift register, bit 0 first. Everything
  // above the data (and parity, if present) stays 1, which gives the stop
  // bits for free.
  always_comb begin
    load_frame             = '1;
    load_frame[0]          = 1'b0;
    load_frame[DATA_W:1]   = data_in;
    if (PARITY_EN != 0) begin
      load_frame[DATA_W+1] = parity_bit;
    end
  end

  // A shift only counts while a frame is actually in flight.
  assign shift_qual = ctrl_sr_shift & ctrl_baud & (state_q == ST_SHIFTING);

  // Next-state logic. A load always wins over a shift in the same cycle and
  // restarts the frame from the start bit; if the previous frame was still
  // busy it is abandoned without a completion pulse and the overrun flag
  // latches until reset.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    count_d        = count_q;
    tx_d           = tx_q;
    busy_d         = busy_q;
    ctrl_counter_d = 1'b0;
    err_overrun_d  = err_overrun_q;

    if (ctrl_sr_load) begin
      if (busy_q) begin
        err_overrun_d = 1'b1;
      end
      shreg_d = load_frame;
      count_d = '0;
      busy_d  = 1'b1;
      tx_d    = load_frame[0];
      state_d = ST_SHIFTING;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
        end

        ST_SHIFTING: begin
          if (shift_qual) begin
            shreg_d = {1'b1, shreg_q[FRAME_LEN-1:1]};
            count_d = count_q + CNT_ONE;
            // After the last frame bit has had its full baud period the line
            // returns to idle and the frame is complete.
            if (count_d == CNT_LAST) begin
              state_d = ST_DONE;
              tx_d    = 1'b1;
            end else begin
              tx_d    = shreg_d[0];
            end
          end
        end

        ST_DONE: begin
          state_d        = ST_IDLE;
          ctrl_counter_d = 1'b1;
          busy_d         = 1'b0;
          tx_d           = 1'b1;
        end

        default: begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  // State register. Reset forces the idle line level immediately, even in
  // the middle of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '1;
      count_q        <= '0;
      tx_q           <= 1'b1;
      busy_q         <= 1'b0;
      ctrl_counter_q <= 1'b0;
      err_overrun_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      count_q        <= count_d;
      tx_q           <= tx_d;
      busy_q         <= busy_d;
      ctrl_counter_q <= ctrl_counter_d;
      err_overrun_q  <= err_overrun_d;
    end
  end

  assign tx           = tx_q;
  assign ctrl_counter = ctrl_counter_q;
  assign busy         = busy_q;
  assign err_overrun  = err_overrun_q;

endmodule

// File: tb/tb_tx_shift_datapath.sv
// -----------------------------------------------------------------------------
// tb_tx_shift_datapath
//
// Drives four differently configured instances of tx_shift_datapath with the
// same control and data inputs:
//   inst 0 : 8 data bits, no parity, 1 stop bit
//   inst 1 : 8 data bits, even parity, 1 stop bit
//   inst 2 : 8 data bits, no parity, 2 stop bits
//   inst 3 : 7 data bits, odd parity, 1 stop bit
// A frame-level reference model (bit list plus position) predicts every output
// of every instance after each clock edge.
// -----------------------------------------------------------------------------
module tb_tx_shift_datapath;

  localparam int N = 4;

  logic       clk;
  logic       reset;
  logic       ctrl_sr_load;
  logic       ctrl_sr_shift;
  logic       ctrl_baud;
  logic [7:0] data_in;

  logic [N-1:0] tx_v;
  logic [N-1:0] cc_v;
  logic [N-1:0] busy_v;
  logic [N-1:0] ovr_v;

  int n_cmp;
  int n_bad;
  int pulse_cnt[N];

  // Reference model state: the frame being sent as a plain bit list, the index
  // of the bit currently on the line, and the observable flags.
  logic [15:0] m_frame[N];
  int          m_len[N];
  int          m_pos[N];
  bit          m_send[N];
  bit          m_done[N];
  bit          m_busy[N];
  bit          m_ovr[N];
  bit          m_tx[N];
  bit          m_pulse[N];

  tx_shift_datapath #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .ctrl_sr_load(ctrl_sr_load), .ctrl_sr_shift(ctrl_sr_shift),
    .ctrl_baud(ctrl_baud), .data_in(data_in), .tx(tx_v[0]), .ctrl_counter(cc_v[0]),
    .busy(busy_v[0]), .err_overrun(ovr_v[0])
  );

  tx_shift_datapath #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .ctrl_sr_load(ctrl_sr_load), .ctrl_sr_shift(ctrl_sr_shift),
    .ctrl_baud(ctrl_baud), .data_in(data_in), .tx(tx_v[1]), .ctrl_counter(cc_v[1]),
    .busy(busy_v[1]), .err_overrun(ovr_v[1])
  );

  tx_shift_datapath #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .ctrl_sr_load(ctrl_sr_load), .ctrl_sr_shift(ctrl_sr_shift),
    .ctrl_baud(ctrl_baud), .data_in(data_in), .tx(tx_v[2]), .ctrl_counter(cc_v[2]),
    .busy(busy_v[2]), .err_overrun(ovr_v[2])
  );

  tx_shift_datapath #(.DATA_W(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut3 (
    .clk(clk), .reset(reset), .ctrl_sr_load(ctrl_sr_load), .ctrl_sr_shift(ctrl_sr_shift),
    .ctrl_baud(ctrl_baud), .data_in(data_in[6:0]), .tx(tx_v[3]), .ctrl_counter(cc_v[3]),
    .busy(busy_v[3]), .err_overrun(ovr_v[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration, mirroring the parameter overrides above.
  function automatic int cfg_dw(input int i);
    return (i == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_pe(input int i);
    return (i == 1 || i == 3) ? 1 : 0;
  endfunction

  function automatic int cfg_po(input int i);
    return (i == 3) ? 1 : 0;
  endfunction

  function automatic int cfg_sb(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // Frame as a list of line levels in transmission order.
  function automatic logic [15:0] build_frame(input int i, input logic [7:0] d);
    logic [15:0] f;
    int          ones;
    int          dw;
    f    = 16'hFFFF;
    dw   = cfg_dw(i);
    ones = 0;
    f[0] = 1'b0;
    for (int b = 0; b < dw; b++) begin
      f[1+b] = d[b];
      if (d[b]) ones++;
    end
    if (cfg_pe(i) != 0) begin
      f[1+dw] = ((ones % 2) == 1) ^ (cfg_po(i) != 0);
    end
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_frame[i] = 16'hFFFF;
      m_len[i]   = 0;
      m_pos[i]   = 0;
      m_send[i]  = 0;
      m_done[i]  = 0;
      m_busy[i]  = 0;
      m_ovr[i]   = 0;
      m_tx[i]    = 1;
      m_pulse[i] = 0;
    end
  endtask

  // One clock edge of the reference model for the given inputs.
  task automatic model_step(input bit ld, input bit sh, input bit bd, input logic [7:0] d);
    for (int i = 0; i < N; i++) begin
      m_pulse[i] = 0;
      if (ld) begin
        if (m_busy[i]) m_ovr[i] = 1;
        m_frame[i] = build_frame(i, d);
        m_len[i]   = 1 + cfg_dw(i) + cfg_pe(i) + cfg_sb(i);
        m_pos[i]   = 0;
        m_send[i]  = 1;
        m_done[i]  = 0;
        m_busy[i]  = 1;
        m_tx[i]    = m_frame[i][0];
      end else if (m_done[i]) begin
        m_done[i]  = 0;
        m_busy[i]  = 0;
        m_pulse[i] = 1;
        m_tx[i]    = 1;
      end else if (m_send[i] && sh && bd) begin
        m_pos[i]++;
        if (m_pos[i] >= m_len[i]) begin
          m_send[i] = 0;
          m_done[i] = 1;
          m_tx[i]   = 1;
        end else begin
          m_tx[i]   = m_frame[i][m_pos[i]];
        end
      end else if (!m_send[i]) begin
        m_tx[i] = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("tx%0d", i),    32'(tx_v[i]),   32'(m_tx[i]));
      checkOutput($sformatf("busy%0d", i),  32'(busy_v[i]), 32'(m_busy[i]));
      checkOutput($sformatf("pulse%0d", i), 32'(cc_v[i]),   32'(m_pulse[i]));
      checkOutput($sformatf("ovr%0d", i),   32'(ovr_v[i]),  32'(m_ovr[i]));
    end
  endtask

  // Apply inputs for one cycle, step the model with the edge, then sample
  // the DUT outputs 1 time unit after the edge.
  task automatic applyStimulus(input bit ld, input bit sh, input bit bd, input logic [7:0] d);
    ctrl_sr_load  = ld;
    ctrl_sr_shift = sh;
    ctrl_baud     = bd;
    data_in       = d;
    @(posedge clk);
    model_step(ld, sh, bd, d);
    #1;
    for (int i = 0; i < N; i++) pulse_cnt[i] += int'(cc_v[i]);
    checkAll();
  endtask

  // A baud tick preceded by a few cycles of shift enable without the tick.
  task automatic tickAfterGap(input int gap);
    for (int g = 0; g < gap; g++) applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 1, 1, 8'h00);
  endtask

  logic [9:0] exp_a5;

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
    exp_a5        = 10'b1101001010;
    reset         = 1'b0;
    ctrl_sr_load  = 1'b0;
    ctrl_sr_shift = 1'b0;
    ctrl_baud     = 1'b0;
    data_in       = 8'h00;
    model_reset();

    // Reset state
    #12;
    checkAll();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 8'h00);

    // Reset in the middle of a frame acts without waiting for a clock edge
    applyStimulus(1, 0, 0, 8'h5A);
    for (int k = 0; k < 4; k++) tickAfterGap(1);
    checkOutput("midframe_busy_before", 32'(busy_v[0]), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_tx",    32'(tx_v[0]),   32'd1);
    checkOutput("rst_busy",  32'(busy_v[0]), 32'd0);
    checkOutput("rst_pulse", 32'(cc_v[0]),   32'd0);
    checkAll();
    reset = 1'b1;
    applyStimulus(0, 1, 1, 8'h00);

    // 0xA5 frame, each bit held across a multi-cycle baud period
    applyStimulus(1, 0, 0, 8'hA5);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("a5_bit%0d", k), 32'(tx_v[0]), 32'(exp_a5[k]));
      tickAfterGap(2);
    end
    checkOutput("a5_pulse_early", 32'(cc_v[0]),   32'd0);
    checkOutput("a5_busy_done",   32'(busy_v[0]), 32'd1);
    applyStimulus(0, 1, 1, 8'h00);
    checkOutput("a5_pulse",      32'(cc_v[0]),   32'd1);
    checkOutput("a5_busy_fall",  32'(busy_v[0]), 32'd0);
    applyStimulus(0, 1, 1, 8'h00);
    checkOutput("a5_pulse_once", 32'(cc_v[0]),   32'd0);
    for (int k = 0; k < 4; k++) tickAfterGap(1);

    // 0x00 frame: long run of zeros then two stop bits on instance 2
    applyStimulus(1, 0, 0, 8'h00);
    for (int k = 0; k < 9; k++) tickAfterGap(0);
    checkOutput("z_stop1", 32'(tx_v[2]), 32'd1);
    tickAfterGap(0);
    checkOutput("z_stop2", 32'(tx_v[2]), 32'd1);
    checkOutput("z_nopulse10", 32'(cc_v[2]), 32'd0);
    tickAfterGap(0);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("z_pulse2", 32'(cc_v[2]), 32'd1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 8'h00);

    // Baud ticks without shift enable, then load and shift together
    applyStimulus(1, 0, 0, 8'h96);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, 8'h00);
    applyStimulus(1, 1, 1, 8'h69);
    checkOutput("ldsh_start", 32'(tx_v[0]), 32'd0);
    for (int k = 0; k < 12; k++) tickAfterGap(1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 8'h00);

    // Overrun: restart with new data, only the restarted frame completes
    for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
    applyStimulus(1, 0, 0, 8'h3C);
    for (int k = 0; k < 3; k++) tickAfterGap(1);
    applyStimulus(1, 0, 0, 8'hC3);
    checkOutput("ovr_set", 32'(ovr_v[0]), 32'd1);
    checkOutput("ovr_restart_tx", 32'(tx_v[0]), 32'd0);
    for (int k = 0; k < 12; k++) tickAfterGap(1);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 8'h00);
    checkOutput("ovr_pulses", 32'(pulse_cnt[0]), 32'd1);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 8,
                    $urandom_range(0, 3) == 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
